// File: rtl/counters_pkg.sv
// Shared definitions for the multimode counter family.
//   bin2gray        : binary to reflected-Gray conversion (up to 16 bits)
//   BCD_MAX_DIGIT   : largest legal BCD decade value
//   BCD_MIN_DIGIT   : smallest legal BCD decade value
//   *_MIN / *_MAX   : legal parameter ranges checked at elaboration
package counters_pkg;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   localparam logic [3:0] BCD_MIN_DIGIT = 4'd0;

   localparam int WIDTH_MIN      = 2;
   localparam int WIDTH_MAX      = 16;
   localparam int MODULO_MIN     = 2;
   localparam int BCD_DIGITS_MIN = 1;
   localparam int BCD_DIGITS_MAX = 4;

   function automatic logic [15:0] bin2gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade (0..9) with up/down step, synchronous load and
// carry/borrow output.
//   clk      : clock, rising edge
//   clr      : synchronous active-high clear, highest priority
//   step     : advance this decade by one in the up_dn direction
//   up_dn    : 1 = up, 0 = down
//   load     : load load_val (already clamped to 0..9 by the caller)
//   load_val : value to load
//   digit    : registered decade value
//   tc       : carry (up, at 9) or borrow (down, at 0) while stepping;
//              drives the step input of the next decade
module bcd_decade
   import counters_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       step,
   input  logic       up_dn,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] digit,
   output logic       tc
);

   assign tc = step & (up_dn ? (digit == BCD_MAX_DIGIT) : (digit == BCD_MIN_DIGIT));

   always_ff @(posedge clk) begin
      if (clr) begin
         digit <= BCD_MIN_DIGIT;
      end else if (load) begin
         digit <= load_val;
      end else if (step) begin
         if (up_dn)
            digit <= (digit == BCD_MAX_DIGIT) ? BCD_MIN_DIGIT : digit + 4'd1;
         else
            digit <= (digit == BCD_MIN_DIGIT) ? BCD_MAX_DIGIT : digit - 4'd1;
      end
   end

endmodule

// File: rtl/multimode_counter.sv
// Binary / Gray / BCD up-down counter with modulo wrap, synchronous
// parallel load with clamping, and cascadable terminal-count outputs.
//   clk        : clock, rising edge
//   clr        : synchronous active-high reset, highest priority
//   enable     : count step enable
//   up_dn      : 1 = up, 0 = down
//   load       : synchronous parallel load, priority over enable
//   load_bin   : binary load value (clamped to MODULO-1)
//   load_bcd   : BCD load value, digit 0 in [3:0] (each decade clamped to 9)
//   bin_count  : registered binary count, 0..MODULO-1
//   gray_count : registered Gray code of bin_count (same cycle)
//   bcd_count  : registered BCD count
//   bin_tc     : binary terminal count (combinational)
//   bcd_tc     : BCD terminal count (combinational)
//   load_err   : registered, last load was clamped or had an invalid digit
module multimode_counter
   import counters_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MODULO     = 256,
   parameter int BCD_DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    enable,
   input  logic                    up_dn,
   input  logic                    load,
   input  logic [WIDTH-1:0]        load_bin,
   input  logic [4*BCD_DIGITS-1:0] load_bcd,
   output logic [WIDTH-1:0]        bin_count,
   output logic [WIDTH-1:0]        gray_count,
   output logic [4*BCD_DIGITS-1:0] bcd_count,
   output logic                    bin_tc,
   output logic                    bcd_tc,
   output logic                    load_err
);

   generate
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
          MODULO < MODULO_MIN || MODULO > (1 << WIDTH) ||
          BCD_DIGITS < BCD_DIGITS_MIN || BCD_DIGITS > BCD_DIGITS_MAX) begin : g_bad_params
         $error("multimode_counter: parameter out of range");
      end
   endgenerate

   localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULO - 1);
   // With a full power-of-two range the counter wraps naturally and
   // no load value can exceed MAX_VAL.
   localparam bit               FULL_RANGE = (MODULO == (1 << WIDTH));

   logic [WIDTH-1:0] step_bin;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] next_bin;
   logic             bin_clamp;

   always_comb begin
      step_bin = bin_count;
      if (up_dn) begin
         if (!FULL_RANGE && bin_count == MAX_VAL)
            step_bin = '0;
         else
            step_bin = bin_count + WIDTH'(1);
      end else begin
         if (bin_count == '0)
            step_bin = MAX_VAL;
         else
            step_bin = bin_count - WIDTH'(1);
      end
   end

   assign bin_clamp    = !FULL_RANGE && (load_bin > MAX_VAL);
   assign load_clamped = bin_clamp ? MAX_VAL : load_bin;
   assign next_bin     = load ? load_clamped : (enable ? step_bin : bin_count);

   // BCD chain: step_chain[k] enables decade k, step_chain[k+1] is its carry/borrow.
   logic [BCD_DIGITS:0]   step_chain;
   logic [BCD_DIGITS-1:0] digit_bad;

   assign step_chain[0] = enable & ~load;

   generate
      for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_decade
         logic [3:0] raw_val;
         logic [3:0] clamped_val;

         assign raw_val      = load_bcd[4*k +: 4];
         assign digit_bad[k] = (raw_val > BCD_MAX_DIGIT);
         assign clamped_val  = digit_bad[k] ? BCD_MAX_DIGIT : raw_val;

         bcd_decade u_decade (
            .clk      (clk),
            .clr      (clr),
            .step     (step_chain[k]),
            .up_dn    (up_dn),
            .load     (load),
            .load_val (clamped_val),
            .digit    (bcd_count[4*k +: 4]),
            .tc       (step_chain[k+1])
         );
      end
   endgenerate

   assign bcd_tc = step_chain[BCD_DIGITS];
   assign bin_tc = enable & ~load & (up_dn ? (bin_count == MAX_VAL) : (bin_count == '0));

   // Gray is derived from the next binary value so both update on the same edge.
   always_ff @(posedge clk) begin
      if (clr) begin
         bin_count  <= '0;
         gray_count <= '0;
         load_err   <= 1'b0;
      end else begin
         if (load || enable) begin
            bin_count  <= next_bin;
            gray_count <= WIDTH'(bin2gray(16'(next_bin)));
         end
         if (load)
            load_err <= bin_clamp | (|digit_bad);
      end
   end

endmodule

// File: tb/tb_multimode_counter.sv
module tb_multimode_counter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: WIDTH=8, MODULO=10, BCD_DIGITS=2
   logic       clr, enable, up_dn, load;
   logic [7:0] load_bin, load_bcd;
   logic [7:0] bin_count, gray_count, bcd_count;
   logic       bin_tc, bcd_tc, load_err;

   // DUT B: WIDTH=4, MODULO=16, BCD_DIGITS=1
   logic       clr_b, enable_b, up_dn_b, load_b;
   logic [3:0] load_bin_b, load_bcd_b;
   logic [3:0] bin_b, gray_b, bcd_b;
   logic       bin_tc_b, bcd_tc_b, load_err_b;

   multimode_counter #(.WIDTH(8), .MODULO(10), .BCD_DIGITS(2)) dut_a (
      .clk(clk), .clr(clr), .enable(enable), .up_dn(up_dn), .load(load),
      .load_bin(load_bin), .load_bcd(load_bcd),
      .bin_count(bin_count), .gray_count(gray_count), .bcd_count(bcd_count),
      .bin_tc(bin_tc), .bcd_tc(bcd_tc), .load_err(load_err)
   );

   multimode_counter #(.WIDTH(4), .MODULO(16), .BCD_DIGITS(1)) dut_b (
      .clk(clk), .clr(clr_b), .enable(enable_b), .up_dn(up_dn_b), .load(load_b),
      .load_bin(load_bin_b), .load_bcd(load_bcd_b),
      .bin_count(bin_b), .gray_count(gray_b), .bcd_count(bcd_b),
      .bin_tc(bin_tc_b), .bcd_tc(bcd_tc_b), .load_err(load_err_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Gray codes of 0..9, written out by hand
   logic [7:0] gray10 [10] = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd6, 8'd7, 8'd5, 8'd4, 8'd12, 8'd13};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] prev_g;
      int         e;

      clr = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0;
      load_bin = 8'd0; load_bcd = 8'h00;
      clr_b = 1'b1; enable_b = 1'b0; up_dn_b = 1'b1; load_b = 1'b0;
      load_bin_b = 4'd0; load_bcd_b = 4'd0;
      tick();

      // reset state
      check("rst_bin",  32'(bin_count),  32'd0);
      check("rst_gray", 32'(gray_count), 32'd0);
      check("rst_bcd",  32'(bcd_count),  32'h00);
      check("rst_err",  32'(load_err),   32'd0);

      // 1: up count with modulo-10 wrap
      clr = 1'b0; enable = 1'b1; up_dn = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) begin
         e = i % 10;
         check("up_bin",  32'(bin_count),  32'(e));
         check("up_gray", 32'(gray_count), 32'(gray10[e]));
         check("up_tc",   32'(bin_tc),     (e == 9) ? 32'd1 : 32'd0);
         tick();
      end
      check("up_end_bin",  32'(bin_count),  32'd2);
      check("up_end_gray", 32'(gray_count), 32'd3);
      check("up_end_bcd",  32'(bcd_count),  32'h12);

      // 2: down wrap from zero
      enable = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0; enable = 1'b1; up_dn = 1'b0;
      #1;
      check("dn_bin_tc", 32'(bin_tc), 32'd1);
      check("dn_bcd_tc", 32'(bcd_tc), 32'd1);
      tick();
      check("dn_bin",  32'(bin_count),  32'd9);
      check("dn_gray", 32'(gray_count), 32'd13);
      check("dn_bcd",  32'(bcd_count),  32'h99);

      // 3: BCD carry through 99
      enable = 1'b0; up_dn = 1'b1; load = 1'b1; load_bin = 8'd0; load_bcd = 8'h98;
      tick();
      check("ld98_bcd", 32'(bcd_count), 32'h98);
      check("ld98_err", 32'(load_err),  32'd0);
      load = 1'b0; enable = 1'b1;
      #1;
      check("c98_tc", 32'(bcd_tc), 32'd0);
      tick();
      check("c99_bcd", 32'(bcd_count), 32'h99);
      check("c99_tc",  32'(bcd_tc),    32'd1);
      tick();
      check("c00_bcd", 32'(bcd_count), 32'h00);
      check("c00_tc",  32'(bcd_tc),    32'd0);
      tick();
      check("c01_bcd", 32'(bcd_count), 32'h01);
      check("c01_bin", 32'(bin_count), 32'd3);

      // 4: load clamping and load_err
      enable = 1'b0; load = 1'b1; load_bin = 8'd200; load_bcd = 8'h00;
      tick();
      check("clamp_bin",  32'(bin_count),  32'd9);
      check("clamp_gray", 32'(gray_count), 32'd13);
      check("clamp_err",  32'(load_err),   32'd1);
      load_bin = 8'd3; load_bcd = 8'h3A;
      tick();
      check("bcdclamp_bcd", 32'(bcd_count), 32'h39);
      check("bcdclamp_bin", 32'(bin_count), 32'd3);
      check("bcdclamp_err", 32'(load_err),  32'd1);
      load_bin = 8'd5; load_bcd = 8'h42;
      tick();
      check("valid_bin",  32'(bin_count),  32'd5);
      check("valid_gray", 32'(gray_count), 32'd7);
      check("valid_bcd",  32'(bcd_count),  32'h42);
      check("valid_err",  32'(load_err),   32'd0);

      // 5: priority clr > load > enable, then hold
      clr = 1'b1; load = 1'b1; enable = 1'b1; load_bin = 8'd7; load_bcd = 8'h77;
      tick();
      check("pri_clr_bin",  32'(bin_count),  32'd0);
      check("pri_clr_gray", 32'(gray_count), 32'd0);
      check("pri_clr_bcd",  32'(bcd_count),  32'h00);
      clr = 1'b0; up_dn = 1'b0; load_bin = 8'd4; load_bcd = 8'h27;
      #1;
      check("pri_ld_bintc", 32'(bin_tc), 32'd0);
      check("pri_ld_bcdtc", 32'(bcd_tc), 32'd0);
      tick();
      check("pri_ld_bin",  32'(bin_count),  32'd4);
      check("pri_ld_gray", 32'(gray_count), 32'd6);
      check("pri_ld_bcd",  32'(bcd_count),  32'h27);
      load = 1'b0; enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_bin",  32'(bin_count),  32'd4);
         check("hold_gray", 32'(gray_count), 32'd6);
         check("hold_bcd",  32'(bcd_count),  32'h27);
      end
      // direction change takes effect on the very next enabled edge
      enable = 1'b1; up_dn = 1'b0;
      tick();
      check("dir_dn_bin", 32'(bin_count), 32'd3);
      check("dir_dn_bcd", 32'(bcd_count), 32'h26);
      up_dn = 1'b1;
      tick();
      check("dir_up_bin", 32'(bin_count), 32'd4);
      check("dir_up_bcd", 32'(bcd_count), 32'h27);
      enable = 1'b0;

      // 6: full 4-bit range, Gray single-bit steps across the wrap
      clr_b = 1'b0; enable_b = 1'b1; up_dn_b = 1'b1;
      #1;
      check("b_rst_bin", 32'(bin_b), 32'd0);
      for (int i = 0; i < 32; i++) begin
         check("b_bin", 32'(bin_b),    32'(i % 16));
         check("b_tc",  32'(bin_tc_b), ((i % 16) == 15) ? 32'd1 : 32'd0);
         prev_g = gray_b;
         tick();
         check("b_gray_1bit", 32'($countones(gray_b ^ prev_g)), 32'd1);
      end
      check("b_end_bin",  32'(bin_b),  32'd0);
      check("b_end_gray", 32'(gray_b), 32'd0);
      check("b_end_bcd",  32'(bcd_b),  32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
